// File: rtl/gat_pkg.sv
// Shared definitions for the GAT input BRAM stream loaders: data width,
// loader state encoding and the word-to-byte address shift.
package gat_pkg;

   localparam int TOP_WIDTH  = 32;
   localparam int BYTE_SHIFT = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } loader_state_t;

endpackage

// File: rtl/gat_bram_stream_loader.sv
// Streams host 32-bit words into one GAT input BRAM. A load is armed by a
// start pulse carrying the expected word count. Each accepted stream beat
// becomes one registered BRAM write at the next word address. The loader
// reports completion with a level load_done and flags framing errors on a
// sticky err_len.
module gat_bram_stream_loader #(
   parameter int TOP_WIDTH = gat_pkg::TOP_WIDTH,
   parameter int DEPTH     = 242101,
   parameter int ADDR_W    = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [ADDR_W:0]      num_words,
   input  logic [TOP_WIDTH-1:0] s_tdata,
   input  logic                 s_tvalid,
   output logic                 s_tready,
   input  logic                 s_tlast,
   output logic [TOP_WIDTH-1:0] bram_din,
   output logic                 bram_ena,
   output logic                 bram_wea,
   output logic [ADDR_W+1:0]    bram_addra,
   output logic                 load_done,
   output logic                 busy,
   output logic                 err_len
);

   import gat_pkg::*;

   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

   loader_state_t        r_state;
   logic [ADDR_W-1:0]    r_cnt;
   logic [ADDR_W:0]      r_numWords;
   logic                 r_donePend;
   logic                 r_sTready;
   logic [TOP_WIDTH-1:0] r_bramDin;
   logic                 r_bramEna;
   logic                 r_bramWea;
   logic [ADDR_W+1:0]    r_bramAddra;
   logic                 r_loadDone;
   logic                 r_busy;
   logic                 r_errLen;

   logic                 w_startOk;
   logic                 w_accept;
   logic                 w_lastBeat;
   logic [ADDR_W:0]      w_cntExt;

   // A start is only usable if the requested length fits the BRAM and is
   // non-empty; cnt is widened so it can be compared with the word count.
   assign w_startOk  = start && (num_words != '0) && (num_words <= DEPTH_W);
   assign w_accept   = s_tvalid && r_sTready;
   assign w_cntExt   = {1'b0, r_cnt};
   assign w_lastBeat = (w_cntExt == (r_numWords - (ADDR_W+1)'(1)));

   assign s_tready   = r_sTready;
   assign bram_din   = r_bramDin;
   assign bram_ena   = r_bramEna;
   assign bram_wea   = r_bramWea;
   assign bram_addra = r_bramAddra;
   assign load_done  = r_loadDone;
   assign busy       = r_busy;
   assign err_len    = r_errLen;

   // Loader FSM: arms on start, turns each accepted beat into a one-cycle
   // write strobe, and raises load_done one cycle after the final strobe
   // so the accelerator never sees completion ahead of the last write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_numWords  <= '0;
         r_donePend  <= 1'b0;
         r_sTready   <= 1'b0;
         r_bramDin   <= '0;
         r_bramEna   <= 1'b0;
         r_bramWea   <= 1'b0;
         r_bramAddra <= '0;
         r_loadDone  <= 1'b0;
         r_busy      <= 1'b0;
         r_errLen    <= 1'b0;
      end else begin
         r_bramEna <= 1'b0;
         r_bramWea <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               if (r_donePend) begin
                  r_loadDone <= 1'b1;
                  r_donePend <= 1'b0;
               end
               if (start) begin
                  r_donePend <= 1'b0;
                  r_loadDone <= 1'b0;
                  if (w_startOk) begin
                     r_state    <= LOAD;
                     r_numWords <= num_words;
                     r_cnt      <= '0;
                     r_errLen   <= 1'b0;
                     r_sTready  <= 1'b1;
                     r_busy     <= 1'b1;
                  end else begin
                     r_errLen <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (w_accept) begin
                  r_bramDin   <= s_tdata;
                  r_bramAddra <= {r_cnt, {BYTE_SHIFT{1'b0}}};
                  r_bramEna   <= 1'b1;
                  r_bramWea   <= 1'b1;
                  r_cnt       <= r_cnt + ADDR_W'(1);
                  if (w_lastBeat || s_tlast) begin
                     r_state    <= DONE;
                     r_sTready  <= 1'b0;
                     r_busy     <= 1'b0;
                     r_donePend <= 1'b1;
                     if (w_lastBeat != s_tlast) begin
                        r_errLen <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
